// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream/downstream valid-ready, control and data fields,
// plus the flush/hold hazard controls. slave = the stage, master = its environment.
`timescale 1ns/1ps
interface pipe_stage_reg_if #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 101
);
    logic              flush;
    logic              hold;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_count;

    modport master (
        output flush, hold, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_count
    );

    modport slave (
        input  flush, hold, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush (clears CTRL only) and hold.
// Define PIPE_SKID_EN for the 2-entry skid version with registered in_ready; default is 1 entry.
`timescale 1ns/1ps
module pipe_stage_reg #(
    parameter int unsigned       CTRL_W   = 8,
    parameter int unsigned       DATA_W   = 101,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input logic               clk,
    input logic               rst,
    pipe_stage_reg_if.slave   bus
);

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
`endif
    logic              out_valid;
    logic              in_ready;
    logic              acc;
    logic              deq;

    always_comb begin
        out_valid = (state_q != EMPTY);
`ifdef PIPE_SKID_EN
        in_ready  = (state_q != SKID);
`else
        in_ready  = !out_valid || (bus.out_ready && !bus.hold);
`endif
        acc = bus.in_valid && in_ready;
        deq = out_valid && bus.out_ready && !bus.hold;
    end

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
`ifdef PIPE_SKID_EN
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
`endif
        case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d     = FULL;
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
                end
            end
            FULL: begin
                if (acc && deq) begin
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
`ifdef PIPE_SKID_EN
                end else if (acc) begin
                    state_d     = SKID;
                    skid_ctrl_d = bus.in_ctrl;
                    skid_data_d = bus.in_data;
`endif
                end else if (deq) begin
                    state_d = EMPTY;
                end
            end
`ifdef PIPE_SKID_EN
            SKID: begin
                if (deq) begin
                    state_d     = FULL;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
        // flush overrides any load: entries die, control is cleared, data regs stay untouched
        if (bus.flush) begin
            state_d     = EMPTY;
            main_ctrl_d = CTRL_RST;
            main_data_d = main_data_q;
`ifdef PIPE_SKID_EN
            skid_ctrl_d = CTRL_RST;
            skid_data_d = skid_data_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= CTRL_RST;
            main_data_q <= '0;
`ifdef PIPE_SKID_EN
            skid_ctrl_q <= CTRL_RST;
            skid_data_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
`ifdef PIPE_SKID_EN
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
`endif
        end
    end

    always_comb begin
        bus.out_valid = out_valid;
        bus.in_ready  = in_ready;
        bus.out_ctrl  = out_valid ? main_ctrl_q : CTRL_RST;
        bus.out_data  = main_data_q;
`ifdef PIPE_SKID_EN
        case (state_q)
            FULL:    bus.out_count = 2'd1;
            SKID:    bus.out_count = 2'd2;
            default: bus.out_count = 2'd0;
        endcase
`else
        bus.out_count = {1'b0, state_q == FULL};
`endif
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted entries are queued, checked in order on dequeue.
// Works with or without PIPE_SKID_EN defined (stage capacity follows the macro).
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    localparam int unsigned       CW   = 8;
    localparam int unsigned       DW   = 101;
    localparam logic [CW-1:0]     CRST = 8'h3C;
`ifdef PIPE_SKID_EN
    localparam int                MAXC = 2;
`else
    localparam int                MAXC = 1;
`endif

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(CRST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic          last_acc;
    logic [DW-1:0] saved;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input logic ordy, input logic h, input logic f);
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.hold      = h;
        bus.flush     = f;
    endtask

    // Called right after a negedge with inputs already driven; returns at the following negedge.
    task automatic step();
        logic exp_rdy;
        ent_t e, inp;
        #1;
        last_acc = 1'b0;
        inp      = '{c: bus.in_ctrl, d: bus.in_data};
        if (!rst) begin
            check_eq("out_valid", 128'(bus.out_valid), 128'(sb.size() != 0));
            check_eq("out_count", 128'(bus.out_count), 128'(sb.size()));
`ifdef PIPE_SKID_EN
            exp_rdy = (sb.size() < MAXC);
`else
            exp_rdy = (sb.size() == 0) || (bus.out_ready && !bus.hold);
`endif
            check_eq("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
            if (bus.out_valid && bus.out_ready && !bus.hold && sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("out_data", 128'(bus.out_data), 128'(e.d));
                check_eq("out_ctrl", 128'(bus.out_ctrl), 128'(e.c));
            end else if (!bus.out_valid) begin
                check_eq("out_ctrl_bubble", 128'(bus.out_ctrl), 128'(CRST));
            end
            last_acc = bus.in_valid && bus.in_ready;
        end
        @(posedge clk);
        if (rst || bus.flush) sb.delete();
        else if (last_acc) sb.push_back(inp);
        @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_in_ready",  128'(bus.in_ready),  128'(1));
        check_eq("rst_out_ctrl",  128'(bus.out_ctrl),  128'(CRST));
        check_eq("rst_out_data",  128'(bus.out_data),  128'(0));
        check_eq("rst_out_count", 128'(bus.out_count), 128'(0));
    endtask

    task automatic idle_drain(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic fill_to_max(input logic [CW-1:0] cbase);
        int tries = 0;
        while (sb.size() < MAXC && tries < 10) begin
            drive(1'b1, cbase + CW'(tries), DW'(100 + tries), 1'b0, 1'b0, 1'b0);
            step();
            tries++;
        end
        check_eq("fill_size", 128'(sb.size()), 128'(MAXC));
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check_reset_vals();
        step();

        // streaming: 8 back-to-back entries
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, CW'(i + 1), DW'(i), 1'b1, 1'b0, 1'b0);
            step();
            check_eq("stream_acc", 128'(last_acc), 128'(1));
        end
        idle_drain(3);

        // backpressure: 1,2,3 with out_ready low, then release
        drive(1'b1, 8'h11, DW'(1), 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 8'h12, DW'(2), 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 8'h13, DW'(3), 1'b0, 1'b0, 1'b0); step();
        check_eq("bp_held", 128'(last_acc), 128'(0));
        begin
            int tries = 0;
            do begin
                drive(1'b1, 8'h13, DW'(3), 1'b1, 1'b0, 1'b0);
                step();
                tries++;
            end while (!last_acc && tries < 10);
            check_eq("bp_accept3", 128'(last_acc), 128'(1));
        end
        idle_drain(4);
        check_eq("bp_drained", 128'(sb.size()), 128'(0));

        // hold while FULL with out_ready high
        drive(1'b1, 8'h21, DW'(33), 1'b1, 1'b0, 1'b0); step();
        saved = bus.out_data;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, CW'(8'h30 + i), DW'(40 + i), 1'b1, 1'b1, 1'b0);
            step();
            check_eq("hold_frozen", 128'(bus.out_data), 128'(saved));
        end
        idle_drain(4);

        // flush when full, with a valid input in the flush cycle
        fill_to_max(8'h50);
        saved = bus.out_data;
        drive(1'b1, 8'hFF, DW'(12'h1FF), 1'b0, 1'b0, 1'b1); step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("flush_valid", 128'(bus.out_valid), 128'(0));
        check_eq("flush_ctrl",  128'(bus.out_ctrl),  128'(CRST));
        check_eq("flush_count", 128'(bus.out_count), 128'(0));
        check_eq("flush_data",  128'(bus.out_data),  128'(saved));
        // flush while empty: the accepted input must be discarded, data regs untouched
        drive(1'b1, 8'hFF, DW'(12'h2AA), 1'b1, 1'b0, 1'b1); step();
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("flush_empty_valid", 128'(bus.out_valid), 128'(0));
        check_eq("flush_empty_data",  128'(bus.out_data),  128'(saved));
        step();

        // rst beats flush and hold
        fill_to_max(8'h60);
        drive(1'b1, 8'h77, DW'(77), 1'b1, 1'b1, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check_reset_vals();
        // flush beats hold
        fill_to_max(8'h70);
        drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b1); step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("flush_hold_valid", 128'(bus.out_valid), 128'(0));
        check_eq("flush_hold_count", 128'(bus.out_count), 128'(0));
        step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), CW'($urandom),
                  DW'({$urandom, $urandom, $urandom, $urandom}),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 49) == 0));
            step();
        end
        idle_drain(6);
        check_eq("final_empty", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
